rom_server: RTL

ROM_SERVER -- requirements
Module: rom_server

---
 rtl/rom_server.sv | 136 +++++++++++++
 1 files changed

// File: rtl/rom_server.sv
// Four-line direct-mapped byte cache in front of a 32-bit backing memory.
// A hit acks one cycle after sampling and a miss acks the cycle after memack; romreq/memreq are held levels.
module rom_server (
  input  logic        clk,
  input  logic        resetn,
  input  logic        init,
  input  logic [21:0] romaddr,
  input  logic        romreq,
  output logic        romack,
  output logic [7:0]  romdata,
  output logic [19:0] memaddr,
  output logic        memreq,
  input  logic        memack,
  input  logic [31:0] memrdata,
  output logic [15:0] hitcnt,
  output logic [15:0] misscnt
);

  typedef enum logic [1:0] {IDLE, FETCH, ACK, GAP} state_t;

  state_t      state_q, state_d;
  logic        romack_q, romack_d;
  logic [7:0]  romdata_q, romdata_d;
  logic [19:0] memaddr_q, memaddr_d;
  logic        memreq_q, memreq_d;
  logic [15:0] hitcnt_q, hitcnt_d;
  logic [15:0] misscnt_q, misscnt_d;
  logic [21:0] addr_q, addr_d;
  logic [3:0]  valid_q, valid_d;
  logic [17:0] tag_q  [4];
  logic [17:0] tag_d  [4];
  logic [31:0] line_q [4];
  logic [31:0] line_d [4];

  logic [1:0]  lk_idx;
  logic [1:0]  fill_idx;
  logic        lk_hit;

  function automatic logic [7:0] byte_sel(input logic [31:0] w, input logic [1:0] s);
    return w[8*s +: 8];
  endfunction

  assign lk_idx   = romaddr[3:2];
  assign fill_idx = addr_q[3:2];
  assign lk_hit   = valid_q[lk_idx] && (tag_q[lk_idx] == romaddr[21:4]) && !init;

  always_comb begin
    state_d   = state_q;
    romack_d  = romack_q;
    romdata_d = romdata_q;
    memaddr_d = memaddr_q;
    memreq_d  = memreq_q;
    hitcnt_d  = hitcnt_q;
    misscnt_d = misscnt_q;
    addr_d    = addr_q;
    valid_d   = valid_q;
    tag_d     = tag_q;
    line_d    = line_q;

    case (state_q)
      IDLE: begin
        if (romreq) begin
          addr_d = romaddr;
          if (lk_hit) begin
            romdata_d = byte_sel(line_q[lk_idx], romaddr[1:0]);
            hitcnt_d  = (hitcnt_q == 16'hFFFF) ? hitcnt_q : hitcnt_q + 16'd1;
            romack_d  = 1'b1;
            state_d   = ACK;
          end else begin
            memaddr_d = romaddr[21:2];
            memreq_d  = 1'b1;
            misscnt_d = (misscnt_q == 16'hFFFF) ? misscnt_q : misscnt_q + 16'd1;
            state_d   = FETCH;
          end
        end
      end
      FETCH: begin
        if (memack) begin
          memreq_d          = 1'b0;
          line_d[fill_idx]  = memrdata;
          tag_d[fill_idx]   = addr_q[21:4];
          valid_d[fill_idx] = 1'b1;
          romdata_d         = byte_sel(memrdata, addr_q[1:0]);
          romack_d          = 1'b1;
          state_d           = ACK;
        end
      end
      ACK: begin
        romack_d = 1'b0;
        state_d  = GAP;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // init overrides any fill this cycle, so a line filled under init stays invalid
    if (init) valid_d = 4'b0000;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= IDLE;
      romack_q  <= 1'b0;
      romdata_q <= 8'h00;
      memaddr_q <= 20'h00000;
      memreq_q  <= 1'b0;
      hitcnt_q  <= 16'h0000;
      misscnt_q <= 16'h0000;
      addr_q    <= 22'h000000;
      valid_q   <= 4'b0000;
      tag_q     <= '{default: '0};
      line_q    <= '{default: '0};
    end else begin
      state_q   <= state_d;
      romack_q  <= romack_d;
      romdata_q <= romdata_d;
      memaddr_q <= memaddr_d;
      memreq_q  <= memreq_d;
      hitcnt_q  <= hitcnt_d;
      misscnt_q <= misscnt_d;
      addr_q    <= addr_d;
      valid_q   <= valid_d;
      tag_q     <= tag_d;
      line_q    <= line_d;
    end
  end

  assign romack  = romack_q;
  assign romdata = romdata_q;
  assign memaddr = memaddr_q;
  assign memreq  = memreq_q;
  assign hitcnt  = hitcnt_q;
  assign misscnt = misscnt_q;

endmodule
